// File: rtl/nbody_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nbody_step_ctrl_if
// Desc     : Controller <-> force datapath bus: pair issue, body update, result strobe.
// Revision : 1.0
// ============================================================================
interface nbody_step_ctrl_if #(
    parameter int BODY_ADDR_WIDTH = 9
);
    logic                       issue_valid;
    logic [BODY_ADDR_WIDTH-1:0] issue_i;
    logic [BODY_ADDR_WIDTH-1:0] issue_j;
    logic                       issue_self;
    logic                       issue_last_j;
    logic                       upd_en;
    logic [BODY_ADDR_WIDTH-1:0] upd_idx;
    logic                       res_valid;

    modport master (
        output issue_valid, issue_i, issue_j, issue_self, issue_last_j,
        output upd_en, upd_idx,
        input  res_valid
    );

    modport slave (
        input  issue_valid, issue_i, issue_j, issue_self, issue_last_j,
        input  upd_en, upd_idx,
        output res_valid
    );
endinterface
`default_nettype wire

// File: rtl/nbody_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nbody_step_ctrl
// Desc     : Walks all (i,j) pairs into the force pipe, drains results, updates bodies.
// Revision : 1.0
// ============================================================================
module nbody_step_ctrl #(
    parameter int BODY_ADDR_WIDTH = 9,
    parameter int GAP_WIDTH       = 32,
    parameter int PIPE_LATENCY    = 122
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic                       read_req,
    input  logic [BODY_ADDR_WIDTH:0]   n_bodies,
    input  logic [GAP_WIDTH-1:0]       gap,
    nbody_step_ctrl_if.master          dp,
    output logic                       mem_host_sel,
    output logic                       busy,
    output logic                       done,
    output logic [GAP_WIDTH-1:0]       step_count,
    output logic                       err
);

    localparam int c_N_W      = BODY_ADDR_WIDTH + 1;
    localparam int c_P_W      = 2 * BODY_ADDR_WIDTH + 1;
    localparam int c_WD_LIMIT = 2 * PIPE_LATENCY;
    localparam int c_WD_W     = $clog2(c_WD_LIMIT + 1);

    localparam logic [c_N_W-1:0]           c_MAX_N    = c_N_W'(1) << BODY_ADDR_WIDTH;
    localparam logic [c_N_W-1:0]           c_N_ONE    = c_N_W'(1);
    localparam logic [BODY_ADDR_WIDTH-1:0] c_IDX_ONE  = BODY_ADDR_WIDTH'(1);
    localparam logic [c_P_W-1:0]           c_P_ONE    = c_P_W'(1);
    localparam logic [c_WD_W-1:0]          c_WD_ONE   = c_WD_W'(1);
    localparam logic [c_WD_W-1:0]          c_WD_LAST  = c_WD_W'(c_WD_LIMIT - 1);
    localparam logic [GAP_WIDTH-1:0]       c_STEP_ONE = GAP_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_DRAIN   = 3'd2,
        S_UPDATE  = 3'd3,
        S_DONE    = 3'd4,
        S_READOUT = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [c_N_W-1:0]           r_n;
    logic [GAP_WIDTH-1:0]       r_g;
    logic [c_P_W-1:0]           r_nn;
    logic [BODY_ADDR_WIDTH-1:0] r_i;
    logic [BODY_ADDR_WIDTH-1:0] r_j;
    logic [BODY_ADDR_WIDTH-1:0] r_upd;
    logic [c_P_W-1:0]           r_ret;
    logic [c_WD_W-1:0]          r_wd;
    logic [GAP_WIDTH-1:0]       r_step;
    logic                       r_err;
    logic                       r_rd_d;

    logic [c_N_W-1:0]           w_n_clamp;
    logic [c_N_W-1:0]           w_n_last;
    logic                       w_i_last;
    logic                       w_j_last;
    logic                       w_u_last;
    logic                       w_cnt_state;
    logic                       w_res_ok;
    logic                       w_stray;
    logic [c_P_W-1:0]           w_ret_next;
    logic [GAP_WIDTH-1:0]       w_step_inc;
    logic                       w_zero_job;
    logic                       w_latch;
    logic                       w_wd_expire;
    logic                       w_rd_rise;
    logic                       w_rd_fall;

    assign w_n_clamp   = (n_bodies > c_MAX_N) ? c_MAX_N : n_bodies;
    assign w_n_last    = r_n - c_N_ONE;
    assign w_i_last    = ({1'b0, r_i}   == w_n_last);
    assign w_j_last    = ({1'b0, r_j}   == w_n_last);
    assign w_u_last    = ({1'b0, r_upd} == w_n_last);
    assign w_zero_job  = (n_bodies == '0) || (gap == '0);
    assign w_step_inc  = r_step + c_STEP_ONE;
    assign w_rd_rise   = read_req & ~r_rd_d;
    assign w_rd_fall   = ~read_req & r_rd_d;

    // A result is only accepted while a sweep is outstanding; anything else is stray.
    assign w_cnt_state = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_res_ok    = dp.res_valid & w_cnt_state & (r_ret != r_nn);
    assign w_stray     = dp.res_valid & ~w_res_ok;
    assign w_ret_next  = w_res_ok ? (r_ret + c_P_ONE) : r_ret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_wd_expire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_latch = 1'b1;
                    w_next  = w_zero_job ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_i_last && w_j_last) begin
                    w_next = (w_ret_next == r_nn) ? S_UPDATE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_ret_next == r_nn) begin
                    w_next = S_UPDATE;
                end else if (!dp.res_valid && (r_wd == c_WD_LAST)) begin
                    w_wd_expire = 1'b1;
                    w_next      = S_DONE;
                end
            end
            S_UPDATE: begin
                if (w_u_last) begin
                    w_next = (w_step_inc == r_g) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                if (w_rd_rise) begin
                    w_next = S_READOUT;
                end
            end
            S_READOUT: begin
                if (w_rd_fall) begin
                    if (go) begin
                        w_latch = 1'b1;
                        w_next  = w_zero_job ? S_DONE : S_ISSUE;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n    <= '0;
            r_g    <= '0;
            r_nn   <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_upd  <= '0;
            r_ret  <= '0;
            r_wd   <= '0;
            r_step <= '0;
            r_err  <= 1'b0;
            r_rd_d <= 1'b0;
        end else begin
            r_rd_d <= read_req;

            if (w_latch) begin
                r_n    <= w_n_clamp;
                r_g    <= gap;
                r_nn   <= c_P_W'(w_n_clamp) * c_P_W'(w_n_clamp);
                r_step <= '0;
            end else if ((r_state == S_UPDATE) && w_u_last) begin
                r_step <= w_step_inc;
            end

            // Index counters rest at zero so every sweep starts at (0,0).
            if (r_state == S_ISSUE) begin
                if (w_j_last) begin
                    r_j <= '0;
                    r_i <= w_i_last ? '0 : (r_i + c_IDX_ONE);
                end else begin
                    r_j <= r_j + c_IDX_ONE;
                end
            end else begin
                r_i <= '0;
                r_j <= '0;
            end

            if (r_state == S_UPDATE) begin
                r_upd <= w_u_last ? '0 : (r_upd + c_IDX_ONE);
            end else begin
                r_upd <= '0;
            end

            r_ret <= w_cnt_state ? w_ret_next : '0;

            if ((r_state == S_DRAIN) && !dp.res_valid) begin
                r_wd <= r_wd + c_WD_ONE;
            end else begin
                r_wd <= '0;
            end

            if (w_stray || w_wd_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dp.issue_valid  = (r_state == S_ISSUE);
    assign dp.issue_i      = r_i;
    assign dp.issue_j      = r_j;
    assign dp.issue_self   = dp.issue_valid & (r_i == r_j);
    assign dp.issue_last_j = dp.issue_valid & w_j_last;
    assign dp.upd_en       = (r_state == S_UPDATE);
    assign dp.upd_idx      = r_upd;

    assign busy         = (r_state == S_ISSUE) || (r_state == S_DRAIN) || (r_state == S_UPDATE);
    assign mem_host_sel = ~busy;
    assign done         = (r_state == S_DONE) || (r_state == S_READOUT);
    assign step_count   = r_step;
    assign err          = r_err;

endmodule
`default_nettype wire
